// File: rtl/cla_digit_serial_addsub.sv
// Digit-serial lookahead adder/subtractor: one DIGIT-bit slice is resolved per RUN cycle.
// Optional zero-result flag output enabled by defining CLA_DIGIT_SERIAL_ZERO_FLAG_EN.
module cla_digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
    logic             r_zacc;
    logic             r_zero;
`endif

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_g;
    logic [DIGIT-1:0] w_p;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_s_dig;
    logic             w_accept;
    logic             w_last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready only in IDLE, out_valid only in DONE, so an output
    // handshake and a new accept can never share an edge.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_ready & in_valid;
    assign w_last    = (r_cnt == LAST_CNT);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
    assign zero      = r_zero;
`endif

    assign w_a_dig = r_a[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_b_dig = r_b[int'(r_cnt) * DIGIT +: DIGIT];
    assign w_g     = w_a_dig & w_b_dig;
    assign w_p     = w_a_dig ^ w_b_dig;

    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            c[i+1] = w_g[i] | (w_p[i] & c[i]);
        end
        w_c = c;
    end

    assign w_s_dig = w_p ^ w_c[DIGIT-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
            r_zacc  <= 1'b0;
            r_zero  <= 1'b0;
`endif
        end else if (w_accept) begin
            // Subtraction is a + ~b + ~borrow, so invert b and the carry-in once here.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
            r_zacc  <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            r_sum[int'(r_cnt) * DIGIT +: DIGIT] <= w_s_dig;
            r_carry <= w_c[DIGIT];
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
            r_zacc  <= r_zacc | (|w_s_dig);
`endif
            if (w_last) begin
                r_cout <= w_c[DIGIT];
                r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
                r_zero <= ~(r_zacc | (|w_s_dig));
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_digit_serial_addsub.sv
// Directed bench for cla_digit_serial_addsub (WIDTH=32, DIGIT=8).
// Zero-flag checks are compiled in when CLA_DIGIT_SERIAL_ZERO_FLAG_EN is defined.
module tb_cla_digit_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
    logic        zero;
`endif
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    cla_digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf),
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
        .zero(zero),
`endif
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    // Present one operand bundle and hold it across exactly one accept edge,
    // then scramble the inputs so later changes would corrupt a wrong design.
    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tcin, input logic tsub);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    endtask

    // Count rising edges after the accept edge until out_valid; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got sum=%h cout=%b ovf=%b out_valid=%b in_ready=%b, required 0/0/0/0/1",
                     sum, cout, ovf, out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_ripple();
        int lat;
        launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL add_ripple_busy: got in_ready=%b, required 0", in_ready);
        end
        wait_done(lat);
        n_vec++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL add_ripple_latency: got %0d cycles, required 4", lat);
        end
        n_vec++;
        if (sum !== 32'h0000_0000 || cout !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL add_ripple_result: got sum=%h cout=%b ovf=%b, required 00000000/1/0", sum, cout, ovf);
        end
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
        n_vec++;
        if (zero !== 1'b1) begin
            n_err++;
            $display("FAIL add_ripple_zero: got zero=%b, required 1", zero);
        end
`endif
        release_result();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL add_ripple_handshake: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub_borrow();
        int lat;
        launch(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        wait_done(lat);
        n_vec++;
        if (lat !== 4 || sum !== 32'hFFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow: got lat=%0d sum=%h cout=%b ovf=%b, required 4/fffffffe/0/0", lat, sum, cout, ovf);
        end
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
        n_vec++;
        if (zero !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow_zero: got zero=%b, required 0", zero);
        end
`endif
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(lat);
        n_vec++;
        if (lat !== 4 || sum !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got lat=%0d sum=%h cout=%b ovf=%b, required 4/80000000/0/1", lat, sum, cout, ovf);
        end
        release_result();
    endtask

    task automatic test_sub_borrow_in();
        int lat;
        launch(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b1);
        wait_done(lat);
        n_vec++;
        if (lat !== 4 || sum !== 32'h0000_00FE || cout !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow_in: got lat=%0d sum=%h cout=%b ovf=%b, required 4/000000fe/1/0", lat, sum, cout, ovf);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        launch(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        wait_done(lat);
        n_vec++;
        if (lat !== 4 || sum !== 32'h0000_0007) begin
            n_err++;
            $display("FAIL backpressure_first: got lat=%0d sum=%h, required 4/00000007", lat, sum);
        end
        @(negedge clk);
        a = 32'h0000_000A; b = 32'h0000_0014; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (sum !== 32'h0000_0007 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: got %0d unstable cycles (last sum=%h out_valid=%b in_ready=%b), required 0",
                     bad, sum, out_valid, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_no_same_cycle_accept: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_second_accept: got in_ready=%b, required 0", in_ready);
        end
        wait_done(lat);
        n_vec++;
        if (lat !== 4 || sum !== 32'h0000_001E || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_second_result: got lat=%0d sum=%h cout=%b ovf=%b, required 4/0000001e/0/0",
                     lat, sum, cout, ovf);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        launch(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_run: got sum=%h cout=%b ovf=%b out_valid=%b in_ready=%b, required 0/0/0/0/1",
                     sum, cout, ovf, out_valid, in_ready);
        end
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
        n_vec++;
        if (zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_run_zero: got zero=%b, required 0", zero);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_abandon: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero();
        int lat;
        launch(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        wait_done(lat);
        n_vec++;
        if (lat !== 4 || sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL zero_result: got lat=%0d sum=%h cout=%b ovf=%b, required 4/00000000/1/0", lat, sum, cout, ovf);
        end
`ifdef CLA_DIGIT_SERIAL_ZERO_FLAG_EN
        n_vec++;
        if (zero !== 1'b1) begin
            n_err++;
            $display("FAIL zero_flag: got zero=%b, required 1", zero);
        end
`endif
        release_result();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        test_reset();
        test_add_ripple();
        test_sub_borrow();
        test_overflow();
        test_sub_borrow_in();
        test_backpressure();
        test_reset_mid_run();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
